// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sb_pkg
// Description : Shared types and constants for the sideband message TX
//               scheduler (state encoding, message width, null code,
//               default serialisation/gap timing).
// Revision    : 1.0 - initial release
// ============================================================================
package sb_pkg;

  localparam int SB_MSG_W      = 4;
  localparam logic [SB_MSG_W-1:0] SB_NULL_MSG = 4'b0000;
  localparam int SB_SER_CYCLES = 64;
  localparam int SB_GAP_CYCLES = 32;
  localparam int SB_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } sb_state_e;

  // Counter width wide enough to hold the larger of the two phase lengths
  // minus one, never narrower than one bit.
  function automatic int sb_cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_msg_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sb_msg_fifo
// Description : Registered synchronous message FIFO with flush and
//               simultaneous push/pop (a push at full is accepted when a pop
//               happens in the same cycle). Reports the next-cycle level so
//               the owner can register status derived from it.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_msg_fifo #(
  parameter  int MSG_W = 4,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [MSG_W-1:0] i_wdata,
  input  logic             i_pop,
  output logic [MSG_W-1:0] o_rdata,
  output logic             o_empty,
  output logic [LW-1:0]    o_level,
  output logic [LW-1:0]    o_level_nxt,
  output logic             o_drop
);

  logic [MSG_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_pop_ok  = i_pop & ~w_empty & ~i_flush;
  assign w_push_ok = i_push & (~w_full | w_pop_ok) & ~i_flush;

  // Level bookkeeping: flush wins, otherwise net effect of push and pop.
  always_comb begin
    w_level_nxt = r_level;
    if (i_flush) begin
      w_level_nxt = '0;
    end else if (w_push_ok && !w_pop_ok) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_push_ok && w_pop_ok) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_level <= w_level_nxt;
      if (i_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push_ok) r_wptr <= r_wptr + AW'(1);
        if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata     = r_mem[r_rptr];
  assign o_empty     = w_empty;
  assign o_level     = r_level;
  assign o_level_nxt = w_level_nxt;
  assign o_drop      = i_push & w_full & ~w_pop_ok & ~i_flush;

endmodule
`default_nettype wire

// File: rtl/sb_msg_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sb_msg_tx_scheduler
// Description : Sideband transmit scheduler. Queues encoded messages from the
//               substate wrappers, hands them one at a time to the packet
//               framer over valid/ready, then holds off for the serialisation
//               time plus a mandatory idle gap. Generates busy and a one-cycle
//               busy falling-edge pulse back to the wrappers.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_msg_tx_scheduler
  import sb_pkg::*;
#(
  parameter  int MSG_W      = SB_MSG_W,
  parameter  int FIFO_DEPTH = SB_FIFO_DEPTH,
  parameter  int SER_CYCLES = SB_SER_CYCLES,
  parameter  int GAP_CYCLES = SB_GAP_CYCLES,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [MSG_W-1:0] i_msg,
  input  logic             i_msg_valid,
  output logic [MSG_W-1:0] o_tx_msg,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic             o_falling_edge_busy,
  output logic [LVL_W-1:0] o_level,
  output logic             o_overflow
);

  localparam int CNT_W = sb_cnt_width(SER_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] SER_LAST = CNT_W'(SER_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [MSG_W-1:0] NULL_MSG = MSG_W'(SB_NULL_MSG);

  sb_state_e        r_state;
  sb_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [MSG_W-1:0] r_tx_msg;
  logic             r_busy;
  logic             r_fe;
  logic             r_ovf;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_drop;
  logic             w_busy_nxt;
  logic [MSG_W-1:0] w_head;
  logic [LVL_W-1:0] w_level;
  logic [LVL_W-1:0] w_level_nxt;

  // The null code never enters the queue; a disabled block accepts nothing.
  assign w_push = i_en & i_msg_valid & (i_msg != NULL_MSG);

  sb_msg_fifo #(
    .MSG_W (MSG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (~i_en),
    .i_push      (w_push),
    .i_wdata     (i_msg),
    .i_pop       (w_pop),
    .o_rdata     (w_head),
    .o_empty     (w_empty),
    .o_level     (w_level),
    .o_level_nxt (w_level_nxt),
    .o_drop      (w_drop)
  );

  // Next-state, counter and pop decode; disable forces an immediate flush.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (i_tx_ready) begin
            w_state_nxt = ST_SEND;
            w_cnt_nxt   = '0;
          end
        end
        ST_SEND: begin
          if (r_cnt == SER_LAST) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_cnt_nxt = '0;
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_state_nxt = ST_LOAD;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Busy is registered from next-cycle state/level so it rises the cycle
  // after the first enqueue and its falling edge lines up with the pulse.
  assign w_busy_nxt = (w_state_nxt != ST_IDLE) | (w_level_nxt != '0);

  // State, counter, presented message, busy/edge and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_tx_msg <= '0;
      r_busy   <= 1'b0;
      r_fe     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_fe    <= r_busy & ~w_busy_nxt;
      if (!i_en) begin
        r_tx_msg <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_pop)  r_tx_msg <= w_head;
        if (w_drop) r_ovf    <= 1'b1;
      end
    end
  end

  assign o_tx_msg            = r_tx_msg;
  assign o_tx_valid          = (r_state == ST_LOAD);
  assign o_busy              = r_busy;
  assign o_falling_edge_busy = r_fe;
  assign o_level             = w_level;
  assign o_overflow          = r_ovf;

endmodule
`default_nettype wire
